// File: rtl/or_tree_arbiter.sv
// Round-robin front end for a shared combinational OR tree.
// Requesters compete for a single issue register (S1) that drives the tree.
// The tree's reduced result is captured into an output register (S2) with
// valid/ready handshake on both sides.
module or_tree_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int NUM_INPUT_DATA = 16,
    localparam int ID_W          = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                i_req_valid,
    input  logic [NUM_REQ*NUM_INPUT_DATA-1:0] i_req_data,
    input  logic [NUM_REQ*NUM_INPUT_DATA-1:0] i_req_mask,
    output logic [NUM_REQ-1:0]                o_req_ready,
    output logic                              o_tree_en,
    output logic [NUM_INPUT_DATA-1:0]         o_tree_valid,
    output logic [NUM_INPUT_DATA-1:0]         o_tree_data,
    input  logic                              i_tree_valid,
    input  logic                              i_tree_data,
    output logic                              o_res_valid,
    output logic                              o_res_data,
    output logic                              o_res_ok,
    output logic [ID_W-1:0]                   o_res_id,
    input  logic                              i_res_ready
);

    logic [ID_W-1:0]           ptr;
    logic [ID_W-1:0]           cand;
    logic [ID_W-1:0]           gnt_id;
    logic                      gnt_found;
    logic [NUM_INPUT_DATA-1:0] sel_data;
    logic [NUM_INPUT_DATA-1:0] sel_mask;

    logic                      vld_p1;
    logic [NUM_INPUT_DATA-1:0] data_p1;
    logic [NUM_INPUT_DATA-1:0] mask_p1;
    logic [ID_W-1:0]           id_p1;

    logic                      vld_p2;
    logic                      res_data_p2;
    logic                      res_ok_p2;
    logic [ID_W-1:0]           res_id_p2;

    logic                      s2_load;
    logic                      s1_can_load;
    logic                      accept;
    logic                      tree_on;

    // Round-robin search: first valid requester at or after ptr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((int'(ptr) + i) % NUM_REQ);
            if (!gnt_found && i_req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_id    = cand;
            end
        end
    end

    // Route the granted requester's data and lane mask toward S1.
    always_comb begin
        sel_data = '0;
        sel_mask = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_id == ID_W'(k)) begin
                sel_data = i_req_data[k*NUM_INPUT_DATA +: NUM_INPUT_DATA];
                sel_mask = i_req_mask[k*NUM_INPUT_DATA +: NUM_INPUT_DATA];
            end
        end
    end

    // S2 takes S1 when it is empty or being drained; S1 refills when it is
    // empty or moving into S2 this same cycle. Nothing is granted in reset.
    assign s2_load     = vld_p1 && (!vld_p2 || i_res_ready);
    assign s1_can_load = !vld_p1 || s2_load;
    assign accept      = gnt_found && s1_can_load && !rst;

    // One-hot ready toward the single requester that transfers this cycle.
    always_comb begin
        o_req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            o_req_ready[k] = accept && (gnt_id == ID_W'(k));
        end
    end

    // Tree inputs are forced quiet whenever S1 holds nothing (or in reset).
    assign tree_on      = vld_p1 && !rst;
    assign o_tree_en    = tree_on;
    assign o_tree_data  = tree_on ? data_p1 : '0;
    assign o_tree_valid = tree_on ? mask_p1 : '0;

    // Control state: S1/S2 occupancy, result register and arbitration pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            vld_p2      <= 1'b0;
            res_data_p2 <= 1'b0;
            res_ok_p2   <= 1'b0;
            res_id_p2   <= '0;
            ptr         <= '0;
        end else begin
            // ---- S1 -> S2 boundary ----
            if (s2_load) begin
                vld_p2      <= 1'b1;
                res_data_p2 <= i_tree_data;
                res_ok_p2   <= i_tree_valid;
                res_id_p2   <= id_p1;
            end else if (i_res_ready) begin
                vld_p2      <= 1'b0;
            end
            // ---- request -> S1 boundary ----
            if (accept) begin
                vld_p1 <= 1'b1;
                ptr    <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
            end else if (s2_load) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    // S1 payload; qualified by vld_p1 so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_p1 <= sel_data;
            mask_p1 <= sel_mask;
            id_p1   <= gnt_id;
        end
    end

    assign o_res_valid = vld_p2;
    assign o_res_data  = res_data_p2;
    assign o_res_ok    = res_ok_p2;
    assign o_res_id    = res_id_p2;

endmodule

// File: tb/tb_or_tree_arbiter.sv
// Directed bench for or_tree_arbiter: a 4x16 instance plus a 3x18 instance,
// each closed through a behavioural model of the shared OR tree.
module tb_or_tree_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        rst;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [63:0] req_mask;
    logic [3:0]  req_ready;
    logic        tree_en;
    logic [15:0] tree_vbus;
    logic [15:0] tree_dbus;
    logic        tree_valid;
    logic        tree_data;
    logic        res_valid;
    logic        res_data;
    logic        res_ok;
    logic [1:0]  res_id;
    logic        res_ready;

    logic [2:0]  r18_valid;
    logic [53:0] r18_data;
    logic [53:0] r18_mask;
    logic [2:0]  r18_ready;
    logic        t18_en;
    logic [17:0] t18_vbus;
    logic [17:0] t18_dbus;
    logic        t18_valid;
    logic        t18_data;
    logic        s18_valid;
    logic        s18_data;
    logic        s18_ok;
    logic [1:0]  s18_id;

    // Reference OR tree: ok only when enabled with every lane valid.
    assign tree_valid = tree_en & (&tree_vbus);
    assign tree_data  = tree_valid & (|tree_dbus);
    assign t18_valid  = t18_en & (&t18_vbus);
    assign t18_data   = t18_valid & (|t18_dbus);

    or_tree_arbiter #(.NUM_REQ(4), .NUM_INPUT_DATA(16)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(req_valid), .i_req_data(req_data), .i_req_mask(req_mask),
        .o_req_ready(req_ready),
        .o_tree_en(tree_en), .o_tree_valid(tree_vbus), .o_tree_data(tree_dbus),
        .i_tree_valid(tree_valid), .i_tree_data(tree_data),
        .o_res_valid(res_valid), .o_res_data(res_data), .o_res_ok(res_ok),
        .o_res_id(res_id), .i_res_ready(res_ready)
    );

    or_tree_arbiter #(.NUM_REQ(3), .NUM_INPUT_DATA(18)) dut18 (
        .clk(clk), .rst(rst),
        .i_req_valid(r18_valid), .i_req_data(r18_data), .i_req_mask(r18_mask),
        .o_req_ready(r18_ready),
        .o_tree_en(t18_en), .o_tree_valid(t18_vbus), .o_tree_data(t18_dbus),
        .i_tree_valid(t18_valid), .i_tree_data(t18_data),
        .o_res_valid(s18_valid), .o_res_data(s18_data), .o_res_ok(s18_ok),
        .o_res_id(s18_id), .i_res_ready(1'b1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int k, input logic [15:0] d, input logic [15:0] m);
        req_data[k*16 +: 16] = d;
        req_mask[k*16 +: 16] = m;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 4'hF;
        req_data  = '0;
        req_mask  = '1;
        res_ready = 1'b1;
        r18_valid = '0;
        r18_data  = '0;
        r18_mask  = '1;

        // Reset: outputs cleared, no ready even though everyone requests.
        step();
        step();
        settle();
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_tree_en", 32'(tree_en), 32'h0);
        chk("rst_res_valid", 32'(res_valid), 32'h0);
        chk("rst_res_data", 32'(res_data), 32'h0);
        chk("rst_res_ok", 32'(res_ok), 32'h0);
        chk("rst_res_id", 32'(res_id), 32'h0);
        rst       = 1'b0;
        req_valid = 4'h0;
        step();

        // Single request from req1 (ptr=0 -> first valid is 1).
        set_req(1, 16'h0010, 16'hFFFF);
        req_valid = 4'b0010;
        settle();
        chk("single_ready", 32'(req_ready), 32'h2);
        step();
        req_valid = 4'b0000;
        settle();
        chk("single_tree_en", 32'(tree_en), 32'h1);
        chk("single_tree_data", 32'(tree_dbus), 32'h0010);
        chk("single_res_valid_early", 32'(res_valid), 32'h0);
        step();
        chk("single_res_valid", 32'(res_valid), 32'h1);
        chk("single_res_data", 32'(res_data), 32'h1);
        chk("single_res_ok", 32'(res_ok), 32'h1);
        chk("single_res_id", 32'(res_id), 32'h1);
        chk("single_tree_idle", 32'(tree_en), 32'h0);
        step();
        chk("single_res_clear", 32'(res_valid), 32'h0);

        // Masking: ptr=2. req2 has lane 0 masked, req3 all-valid zero data.
        set_req(2, 16'h0001, 16'hFFFE);
        set_req(3, 16'h0000, 16'hFFFF);
        req_valid = 4'b1100;
        settle();
        chk("mask_ready2", 32'(req_ready), 32'h4);
        step();
        req_valid = 4'b1000;
        settle();
        chk("mask_ready3_backtoback", 32'(req_ready), 32'h8);
        chk("mask_tree_valid", 32'(tree_vbus), 32'hFFFE);
        step();
        req_valid = 4'b0000;
        chk("mask_r2_valid", 32'(res_valid), 32'h1);
        chk("mask_r2_ok", 32'(res_ok), 32'h0);
        chk("mask_r2_data", 32'(res_data), 32'h0);
        chk("mask_r2_id", 32'(res_id), 32'h2);
        step();
        chk("mask_r3_ok", 32'(res_ok), 32'h1);
        chk("mask_r3_data", 32'(res_data), 32'h0);
        chk("mask_r3_id", 32'(res_id), 32'h3);
        step();
        chk("mask_clear", 32'(res_valid), 32'h0);

        // Fairness: ptr=0, all valid, one grant and one result per cycle.
        for (int k = 0; k < 4; k++) set_req(k, 16'h00FF, 16'hFFFF);
        req_valid = 4'hF;
        for (int i = 0; i < 8; i++) begin
            settle();
            chk($sformatf("fair_ready_%0d", i), 32'(req_ready), 32'h1 << (i % 4));
            step();
            if (i >= 1) begin
                chk($sformatf("fair_valid_%0d", i), 32'(res_valid), 32'h1);
                chk($sformatf("fair_id_%0d", i), 32'(res_id), 32'((i - 1) % 4));
            end
        end
        req_valid = 4'h0;
        step();
        chk("fair_last_id", 32'(res_id), 32'h3);
        chk("fair_last_data", 32'(res_data), 32'h1);
        step();
        chk("fair_clear", 32'(res_valid), 32'h0);

        // Backpressure: ptr=0, consumer stalled.
        set_req(0, 16'h0000, 16'hFFFF);
        set_req(1, 16'h1234, 16'hFFFF);
        set_req(2, 16'h0001, 16'hFFFE);
        set_req(3, 16'h0001, 16'hFFFF);
        res_ready = 1'b0;
        req_valid = 4'hF;
        settle();
        chk("bp_ready0", 32'(req_ready), 32'h1);
        step();
        settle();
        chk("bp_ready1", 32'(req_ready), 32'h2);
        step();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold_ready_%0d", i), 32'(req_ready), 32'h0);
            chk($sformatf("bp_hold_valid_%0d", i), 32'(res_valid), 32'h1);
            chk($sformatf("bp_hold_id_%0d", i), 32'(res_id), 32'h0);
            chk($sformatf("bp_hold_ok_%0d", i), 32'(res_ok), 32'h1);
            chk($sformatf("bp_hold_data_%0d", i), 32'(res_data), 32'h0);
            chk($sformatf("bp_hold_s1_%0d", i), 32'(tree_dbus), 32'h1234);
            step();
        end
        res_ready = 1'b1;
        settle();
        chk("bp_release_ready", 32'(req_ready), 32'h4);
        step();
        req_valid = 4'h0;
        chk("bp_drain1_id", 32'(res_id), 32'h1);
        chk("bp_drain1_data", 32'(res_data), 32'h1);
        step();
        chk("bp_drain2_id", 32'(res_id), 32'h2);
        chk("bp_drain2_ok", 32'(res_ok), 32'h0);
        step();
        chk("bp_drain_clear", 32'(res_valid), 32'h0);

        // Mid-operation reset: ptr=3, fill S1 and S2, then pulse rst.
        res_ready = 1'b0;
        req_valid = 4'hF;
        settle();
        chk("mr_ready3", 32'(req_ready), 32'h8);
        step();
        settle();
        chk("mr_ready0", 32'(req_ready), 32'h1);
        step();
        chk("mr_full_valid", 32'(res_valid), 32'h1);
        chk("mr_full_id", 32'(res_id), 32'h3);
        chk("mr_full_tree", 32'(tree_en), 32'h1);
        rst = 1'b1;
        settle();
        chk("mr_in_rst_ready", 32'(req_ready), 32'h0);
        chk("mr_in_rst_tree", 32'(tree_en), 32'h0);
        step();
        rst = 1'b0;
        settle();
        chk("mr_res_valid", 32'(res_valid), 32'h0);
        chk("mr_res_id", 32'(res_id), 32'h0);
        chk("mr_tree_en", 32'(tree_en), 32'h0);
        chk("mr_first_grant", 32'(req_ready), 32'h1);
        res_ready = 1'b1;
        step();
        req_valid = 4'h0;
        step();
        chk("mr_after_valid", 32'(res_valid), 32'h1);
        chk("mr_after_id", 32'(res_id), 32'h0);
        step();

        // 18-lane, 3-requester instance: single bit at lane 17.
        r18_data[2*18 +: 18] = 18'h20000;
        r18_valid = 3'b100;
        settle();
        chk("w18_ready", 32'(r18_ready), 32'h4);
        step();
        r18_valid = 3'b000;
        chk("w18_tree_data", 32'(t18_dbus), 32'h20000);
        step();
        chk("w18_res_valid", 32'(s18_valid), 32'h1);
        chk("w18_res_data", 32'(s18_data), 32'h1);
        chk("w18_res_ok", 32'(s18_ok), 32'h1);
        chk("w18_res_id", 32'(s18_id), 32'h2);
        r18_valid = 3'b101;
        settle();
        chk("w18_ptr_wrap", 32'(r18_ready), 32'h1);
        step();
        r18_valid = 3'b000;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
